writeback_arbiter: RTL and testbench

//  Write-side driver of the register file. Merges the fixed-latency ALU result stream with the

---
 rtl/writeback_pkg.sv | 20 ++
 rtl/sync_fifo.sv | 67 ++++++
 rtl/writeback_arbiter.sv | 129 ++++++++++++
 tb/tb_writeback_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/writeback_pkg.sv
// Shared types for the register-file write-back path.
package writeback_pkg;

    localparam int unsigned WB_WORD_SIZE      = 32;
    localparam int unsigned WB_REGISTER_COUNT = 32;
    localparam int unsigned WB_REG_ADR_W      = $clog2(WB_REGISTER_COUNT);

    typedef logic [WB_REG_ADR_W-1:0] reg_adr_t;
    typedef logic [WB_WORD_SIZE-1:0] word_t;

    // One candidate register-file write; is_load marks scoreboard-clearing writes.
    typedef struct packed {
        reg_adr_t rd;
        word_t    data;
        logic     is_load;
    } wb_entry_t;

    localparam reg_adr_t ZERO_REG = '0;

endpackage

// File: rtl/sync_fifo.sv
// Generic in-order synchronous FIFO with registered full/empty and an exposed head entry.
module sync_fifo #(
    parameter type         T     = logic,
    parameter int unsigned DEPTH = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_push,
    input  T     i_data,
    input  logic i_pop,
    output logic o_full,
    output logic o_empty,
    output T     o_head
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    typedef logic [PW-1:0] ptr_t;

    T               r_mem [DEPTH];
    ptr_t           r_wr_ptr;
    ptr_t           r_rd_ptr;
    logic [CW-1:0]  r_count;
    logic           w_do_push;
    logic           w_do_pop;

    function automatic ptr_t next_ptr(input ptr_t p);
        return (p == ptr_t'(DEPTH - 1)) ? '0 : p + ptr_t'(1);
    endfunction

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_head    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty;
    // A push into a full FIFO only lands if the head leaves on the same edge.
    assign w_do_push = i_push && (!o_full || w_do_pop);

    // Storage needs no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= next_ptr(r_wr_ptr);
            end
            if (w_do_pop) begin
                r_rd_ptr <= next_ptr(r_rd_ptr);
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + CW'(1);
            end else if (!w_do_push && w_do_pop) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/writeback_arbiter.sv
// Register-file write port driver: merges ALU and load results and tracks pending loads.
module writeback_arbiter
    import writeback_pkg::*;
#(
    parameter int unsigned WORD_SIZE      = WB_WORD_SIZE,
    parameter int unsigned REGISTER_COUNT = WB_REGISTER_COUNT,
    parameter int unsigned FIFO_DEPTH     = 2
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              alu_valid,
    input  logic [$clog2(REGISTER_COUNT)-1:0] alu_rd,
    input  logic [WORD_SIZE-1:0]              alu_data,
    input  logic                              load_valid,
    output logic                              load_ready,
    input  logic [$clog2(REGISTER_COUNT)-1:0] load_rd,
    input  logic [WORD_SIZE-1:0]              load_data,
    input  logic                              issue_valid,
    input  logic [$clog2(REGISTER_COUNT)-1:0] issue_rd,
    input  logic [$clog2(REGISTER_COUNT)-1:0] rs1Adr,
    input  logic [$clog2(REGISTER_COUNT)-1:0] rs2Adr,
    output logic                              rs1_pending,
    output logic                              rs2_pending,
    output logic                              WriteEnable,
    output logic [$clog2(REGISTER_COUNT)-1:0] rd1Adr,
    output logic [WORD_SIZE-1:0]              Rd1
);

    logic                      r_we;
    wb_entry_t                 r_out;
    logic [REGISTER_COUNT-1:0] r_pending;

    logic                      w_fifo_full;
    logic                      w_fifo_empty;
    logic                      w_fifo_push;
    logic                      w_fifo_pop;
    wb_entry_t                 w_fifo_in;
    wb_entry_t                 w_fifo_head;
    wb_entry_t                 w_sel;
    logic                      w_sel_we;
    logic [REGISTER_COUNT-1:0] w_set_mask;
    logic [REGISTER_COUNT-1:0] w_clr_mask;
    logic [REGISTER_COUNT-1:0] w_pending_d;

    // Ready depends only on registered occupancy, never on this cycle's pop.
    assign load_ready  = reset && !w_fifo_full;
    assign w_fifo_push = load_valid && load_ready;
    assign w_fifo_in   = '{rd: load_rd, data: load_data, is_load: 1'b1};

    sync_fifo #(
        .T     (wb_entry_t),
        .DEPTH (FIFO_DEPTH)
    ) u_load_fifo (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_push  (w_fifo_push),
        .i_data  (w_fifo_in),
        .i_pop   (w_fifo_pop),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_head  (w_fifo_head)
    );

    // Write-port priority: ALU cannot stall, so it always wins over the load FIFO.
    always_comb begin
        w_fifo_pop = 1'b0;
        w_sel      = r_out;
        w_sel_we   = 1'b0;
        if (alu_valid) begin
            w_sel    = '{rd: alu_rd, data: alu_data, is_load: 1'b0};
            w_sel_we = (alu_rd != ZERO_REG);
        end else if (!w_fifo_empty) begin
            w_fifo_pop = 1'b1;
            w_sel      = w_fifo_head;
            w_sel_we   = (w_fifo_head.rd != ZERO_REG);
        end
    end

    // Registered write port; address/data hold when nothing is selected.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_we  <= 1'b0;
            r_out <= '0;
        end else begin
            r_we  <= w_sel_we;
            r_out <= w_sel;
        end
    end

    // Scoreboard next state: a commit clears, a new issue sets, and set wins a tie.
    always_comb begin
        w_set_mask = '0;
        w_clr_mask = '0;
        if (issue_valid && (issue_rd != ZERO_REG)) begin
            w_set_mask[issue_rd] = 1'b1;
        end
        if (r_we && r_out.is_load) begin
            w_clr_mask[r_out.rd] = 1'b1;
        end
        w_pending_d    = (r_pending & ~w_clr_mask) | w_set_mask;
        w_pending_d[0] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pending <= '0;
        end else begin
            r_pending <= w_pending_d;
        end
    end

    assign rs1_pending = (rs1Adr != ZERO_REG) && r_pending[rs1Adr];
    assign rs2_pending = (rs2Adr != ZERO_REG) && r_pending[rs2Adr];
    assign WriteEnable = r_we;
    assign rd1Adr      = r_out.rd;
    assign Rd1         = r_out.data;

    // Decode must not reissue a pending register unless it commits this very cycle.
    a_issue_not_pending : assert property (@(posedge clk) disable iff (!reset)
        (issue_valid && (issue_rd != ZERO_REG)) |-> (!r_pending[issue_rd] || w_clr_mask[issue_rd]));

    a_alu_not_pending : assert property (@(posedge clk) disable iff (!reset)
        (alu_valid && (alu_rd != ZERO_REG)) |-> !r_pending[alu_rd]);

    a_load_was_issued : assert property (@(posedge clk) disable iff (!reset)
        (w_fifo_push && (load_rd != ZERO_REG)) |-> r_pending[load_rd]);

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter with a cycle-stamped write scoreboard.
module tb_writeback_arbiter;

    logic        clk;
    logic        reset;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        load_valid;
    logic        load_ready;
    logic [4:0]  load_rd;
    logic [31:0] load_data;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic [4:0]  rs1Adr;
    logic [4:0]  rs2Adr;
    logic        rs1_pending;
    logic        rs2_pending;
    logic        WriteEnable;
    logic [4:0]  rd1Adr;
    logic [31:0] Rd1;

    typedef struct {
        int          cyc;
        logic [4:0]  adr;
        logic [31:0] data;
    } exp_t;

    exp_t q[$];
    int   cyc     = 0;
    int   n_pass  = 0;
    int   n_total = 0;
    bit   done    = 0;

    writeback_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .alu_valid   (alu_valid),
        .alu_rd      (alu_rd),
        .alu_data    (alu_data),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .load_rd     (load_rd),
        .load_data   (load_data),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .rs1Adr      (rs1Adr),
        .rs2Adr      (rs2Adr),
        .rs1_pending (rs1_pending),
        .rs2_pending (rs2_pending),
        .WriteEnable (WriteEnable),
        .rd1Adr      (rd1Adr),
        .Rd1         (Rd1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Keep the queue sorted by expected write cycle.
    task automatic push_exp(input int c, input logic [4:0] a, input logic [31:0] d);
        exp_t e;
        int   idx;
        e.cyc  = c;
        e.adr  = a;
        e.data = d;
        idx    = q.size();
        for (int j = 0; j < q.size(); j++) begin
            if (q[j].cyc > c) begin
                idx = j;
                break;
            end
        end
        q.insert(idx, e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alu_valid   = 1'b0;
        load_valid  = 1'b0;
        issue_valid = 1'b0;
    endtask

    bit ready_tbl [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    int wr_ofs    [3] = '{5, 6, 7};

    initial begin
        reset     = 1'b0;
        idle();
        alu_rd    = '0;
        alu_data  = '0;
        load_rd   = '0;
        load_data = '0;
        issue_rd  = '0;
        rs1Adr    = '0;
        rs2Adr    = '0;
        fork
            begin : stim
                int base;
                int k;
                // Reset held with toggling inputs.
                repeat (3) begin
                    step();
                    alu_valid   = 1'($urandom);
                    load_valid  = 1'($urandom);
                    issue_valid = 1'($urandom);
                    alu_rd      = 5'($urandom);
                    load_rd     = 5'($urandom);
                    issue_rd    = 5'($urandom);
                    rs1Adr      = 5'($urandom);
                    rs2Adr      = 5'($urandom);
                    alu_data    = $urandom;
                    load_data   = $urandom;
                    #1;
                    chk("rst_we", 32'(WriteEnable), 32'd0);
                    chk("rst_adr", 32'(rd1Adr), 32'd0);
                    chk("rst_data", Rd1, 32'd0);
                    chk("rst_ready", 32'(load_ready), 32'd0);
                    chk("rst_rs1p", 32'(rs1_pending), 32'd0);
                    chk("rst_rs2p", 32'(rs2_pending), 32'd0);
                end
                step();
                idle();
                reset = 1'b1;
                #1;
                chk("rel_ready", 32'(load_ready), 32'd1);

                // ALU only.
                step();
                alu_valid = 1'b1;
                alu_rd    = 5'd5;
                alu_data  = 32'hDEAD_BEEF;
                push_exp(cyc + 1, 5'd5, 32'hDEAD_BEEF);
                step();
                idle();
                step();

                // Load path through the scoreboard.
                step();
                issue_valid = 1'b1;
                issue_rd    = 5'd7;
                step();
                idle();
                rs1Adr = 5'd7;
                #1;
                chk("ld_issue_pend", 32'(rs1_pending), 32'd1);
                step();
                step();
                load_valid = 1'b1;
                load_rd    = 5'd7;
                load_data  = 32'h1234;
                #1;
                chk("ld_ready", 32'(load_ready), 32'd1);
                push_exp(cyc + 2, 5'd7, 32'h1234);
                step();
                idle();
                #1;
                chk("ld_pend_head", 32'(rs1_pending), 32'd1);
                step();
                #1;
                chk("ld_pend_write", 32'(rs1_pending), 32'd1);
                step();
                #1;
                chk("ld_pend_clear", 32'(rs1_pending), 32'd0);

                // Contention: ALU held four cycles, loads offered every cycle.
                for (int j = 0; j < 3; j++) begin
                    step();
                    idle();
                    issue_valid = 1'b1;
                    issue_rd    = 5'(10 + j);
                end
                base = 0;
                k    = 0;
                for (int i = 0; i < 6; i++) begin
                    step();
                    idle();
                    if (i == 0) base = cyc;
                    if (i < 4) begin
                        alu_valid = 1'b1;
                        alu_rd    = 5'(20 + i);
                        alu_data  = 32'hA000_0000 + 32'(i);
                        push_exp(cyc + 1, alu_rd, alu_data);
                    end
                    load_valid = 1'b1;
                    load_rd    = 5'(10 + k);
                    load_data  = 32'h0000_1000 + 32'(10 + k);
                    #1;
                    chk("cont_ready", 32'(load_ready), 32'(ready_tbl[i]));
                    if (ready_tbl[i]) begin
                        push_exp(base + wr_ofs[k], load_rd, load_data);
                        k++;
                    end
                end
                step();
                idle();
                repeat (2) step();
                rs1Adr = 5'd12;
                rs2Adr = 5'd10;
                #1;
                chk("cont_pend12", 32'(rs1_pending), 32'd0);
                chk("cont_pend10", 32'(rs2_pending), 32'd0);

                // Register x0 is never written nor pending; the FIFO still drains.
                step();
                issue_valid = 1'b1;
                issue_rd    = 5'd15;
                step();
                idle();
                alu_valid   = 1'b1;
                alu_rd      = 5'd0;
                alu_data    = 32'h55;
                load_valid  = 1'b1;
                load_rd     = 5'd0;
                load_data   = 32'h66;
                issue_valid = 1'b1;
                issue_rd    = 5'd0;
                #1;
                chk("x0_ready", 32'(load_ready), 32'd1);
                step();
                idle();
                load_valid = 1'b1;
                load_rd    = 5'd15;
                load_data  = 32'hF00D;
                rs1Adr     = 5'd0;
                rs2Adr     = 5'd15;
                #1;
                chk("x0_rs1_pend", 32'(rs1_pending), 32'd0);
                chk("x0_rs2_pend15", 32'(rs2_pending), 32'd1);
                chk("x0_ready2", 32'(load_ready), 32'd1);
                push_exp(cyc + 2, 5'd15, 32'hF00D);
                step();
                idle();
                repeat (3) step();

                // Set/clear collision on register 9.
                step();
                issue_valid = 1'b1;
                issue_rd    = 5'd9;
                step();
                idle();
                load_valid = 1'b1;
                load_rd    = 5'd9;
                load_data  = 32'h99;
                push_exp(cyc + 2, 5'd9, 32'h99);
                step();
                idle();
                step();
                issue_valid = 1'b1;
                issue_rd    = 5'd9;
                rs1Adr      = 5'd9;
                step();
                idle();
                #1;
                chk("coll_pend9", 32'(rs1_pending), 32'd1);

                // Reset mid-stream with two loads buffered.
                step();
                issue_valid = 1'b1;
                issue_rd    = 5'd16;
                step();
                issue_rd = 5'd17;
                step();
                idle();
                alu_valid  = 1'b1;
                alu_rd     = 5'd21;
                alu_data   = 32'hB1;
                load_valid = 1'b1;
                load_rd    = 5'd16;
                load_data  = 32'hC16;
                push_exp(cyc + 1, 5'd21, 32'hB1);
                step();
                alu_rd    = 5'd22;
                alu_data  = 32'hB2;
                load_rd   = 5'd17;
                load_data = 32'hC17;
                push_exp(cyc + 1, 5'd22, 32'hB2);
                step();
                idle();
                alu_valid = 1'b1;
                alu_rd    = 5'd23;
                alu_data  = 32'hB3;
                #1;
                chk("rs_full_ready", 32'(load_ready), 32'd0);
                @(negedge clk);
                #1;
                reset = 1'b0;
                #1;
                chk("rs_we", 32'(WriteEnable), 32'd0);
                chk("rs_adr", 32'(rd1Adr), 32'd0);
                chk("rs_data", Rd1, 32'd0);
                chk("rs_ready", 32'(load_ready), 32'd0);
                step();
                idle();
                reset  = 1'b1;
                rs1Adr = 5'd16;
                rs2Adr = 5'd9;
                #1;
                chk("rs_rel_ready", 32'(load_ready), 32'd1);
                chk("rs_pend16", 32'(rs1_pending), 32'd0);
                chk("rs_pend9", 32'(rs2_pending), 32'd0);
                repeat (6) step();
                done = 1'b1;
            end
            begin : monitor
                exp_t e;
                while (!done) begin
                    @(negedge clk);
                    if (reset) begin
                        if (WriteEnable) begin
                            n_total++;
                            if (q.size() == 0) begin
                                $display("FAIL unexpected_write: got cyc=%0d rd=%0d data=%h, expected no write",
                                         cyc, rd1Adr, Rd1);
                            end else begin
                                e = q.pop_front();
                                if (e.cyc == cyc && e.adr === rd1Adr && e.data === Rd1) n_pass++;
                                else $display("FAIL write: got cyc=%0d rd=%0d data=%h, expected cyc=%0d rd=%0d data=%h",
                                              cyc, rd1Adr, Rd1, e.cyc, e.adr, e.data);
                            end
                        end else if (q.size() > 0 && q[0].cyc < cyc) begin
                            n_total++;
                            e = q.pop_front();
                            $display("FAIL missing_write: got none by cyc=%0d, expected cyc=%0d rd=%0d data=%h",
                                     cyc, e.cyc, e.adr, e.data);
                        end
                    end
                end
            end
        join
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
